tick_generator: RTL and testbench

//  Multi-channel programmable tick (clock-enable) generator on Clk100M. Replaces the fixed SymGen/1Hz/Disp dividers.

---
 rtl/tick_gen_pkg.sv | 19 +
 rtl/tick_channel.sv | 59 +++++
 rtl/tick_generator.sv | 111 +++++++++++
 tb/tb_tick_generator.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants and types for the tick generator and its consumers.
package tick_gen_pkg;

    localparam int unsigned CLK_HZ         = 100_000_000;
    localparam int unsigned ONE_SEC        = 100_000_000;
    localparam int unsigned DISP_PERIOD    = 5_000_000;
    localparam int unsigned DEF_LVL_STEP   = 5_000_000;
    localparam int unsigned DEF_MIN_PERIOD = 1_000_000;

    localparam int unsigned CH_SYM  = 0;
    localparam int unsigned CH_1HZ  = 1;
    localparam int unsigned CH_DISP = 2;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: period counter with armed/done flags and periodic/one-shot mode.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int unsigned CNT_W = 27
) (
    input  logic             Clk100M,
    input  logic             resetB,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic             modeWe,
    input  logic             oneshot,
    input  logic [CNT_W-1:0] period,
    output logic             tick,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cntQ;
    logic             armedQ;
    mode_e            modeQ;

    always_ff @(posedge Clk100M) begin
        if (resetB) begin
            cntQ   <= '0;
            armedQ <= 1'b1;
            modeQ  <= MODE_PERIODIC;
            tick   <= 1'b0;
            done   <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (modeWe) begin
                modeQ <= oneshot ? MODE_ONESHOT : MODE_PERIODIC;
            end
            if (clr) begin
                armedQ <= 1'b1;
                done   <= 1'b0;
            end
            // Restart (clear or reload) takes priority over counting.
            if (clr || load) begin
                cntQ <= '0;
            end else if (en && armedQ) begin
                if (cntQ == period - ONE) begin
                    cntQ <= '0;
                    tick <= 1'b1;
                    if (modeQ == MODE_ONESHOT) begin
                        armedQ <= 1'b0;
                        done   <= 1'b1;
                    end
                end else begin
                    cntQ <= cntQ + ONE;
                end
            end
        end
    end

endmodule

// File: rtl/tick_generator.sv
// Multi-channel programmable tick generator; one channel's period shrinks with game level.
module tick_generator
    import tick_gen_pkg::*;
#(
    parameter int unsigned NUM_CH         = 3,
    parameter int unsigned CNT_W          = 27,
    parameter int unsigned LVL_W          = 5,
    parameter int unsigned ADJ_CH         = CH_SYM,
    parameter int unsigned LVL_STEP       = DEF_LVL_STEP,
    parameter int unsigned MIN_PERIOD     = DEF_MIN_PERIOD,
    parameter int unsigned DEFAULT_PERIOD = ONE_SEC,
    localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              Clk100M,
    input  logic              resetB,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] ch_clr,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_oneshot,
    input  logic              lvl_load,
    input  logic [LVL_W-1:0]  level,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] done,
    output logic [CNT_W-1:0]  eff_period
);

    localparam int unsigned      PW      = CNT_W + LVL_W;
    localparam logic [CNT_W-1:0] DEF_P   = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [PW-1:0]    STEP_P  = PW'(LVL_STEP);
    localparam logic [CH_W-1:0]  ADJ_IDX = CH_W'(ADJ_CH);

    logic [CNT_W-1:0] baseQ [NUM_CH];
    logic [LVL_W-1:0] lvlQ;
    logic [CNT_W-1:0] adjEffQ;

    logic [CNT_W-1:0] wrPeriod;
    logic             adjWr;
    logic [CNT_W-1:0] adjBaseNext;
    logic [LVL_W-1:0] lvlNext;

    // Wide subtraction guarded so the effective period never wraps below the floor.
    function automatic logic [CNT_W-1:0] clampEff(input logic [CNT_W-1:0] b,
                                                   input logic [LVL_W-1:0] l);
        logic [PW-1:0] prod;
        logic [PW-1:0] diff;
        prod = PW'(l) * STEP_P;
        if (prod >= PW'(b)) begin
            return MIN_P;
        end
        diff = PW'(b) - prod;
        if (diff < PW'(MIN_P)) begin
            return MIN_P;
        end
        return diff[CNT_W-1:0];
    endfunction

    always_comb begin
        wrPeriod    = (cfg_period == '0) ? ONE : cfg_period;
        adjWr       = cfg_we && (cfg_ch == ADJ_IDX);
        adjBaseNext = adjWr ? wrPeriod : baseQ[ADJ_CH];
        lvlNext     = lvl_load ? level : lvlQ;
    end

    always_ff @(posedge Clk100M) begin
        if (resetB) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                baseQ[i] <= DEF_P;
            end
            lvlQ    <= '0;
            adjEffQ <= DEF_P;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (cfg_we && (cfg_ch == CH_W'(i))) begin
                    baseQ[i] <= wrPeriod;
                end
            end
            lvlQ <= lvlNext;
            if (adjWr || lvl_load) begin
                adjEffQ <= clampEff(adjBaseNext, lvlNext);
            end
        end
    end

    assign eff_period = adjEffQ;

    for (genvar g = 0; g < NUM_CH; g++) begin : gCh
        localparam logic [CH_W-1:0] IDX    = CH_W'(g);
        localparam bit              IS_ADJ = (g == int'(ADJ_CH));

        logic wrHit;
        assign wrHit = cfg_we && (cfg_ch == IDX);

        tick_channel #(.CNT_W(CNT_W)) uCh (
            .Clk100M (Clk100M),
            .resetB  (resetB),
            .en      (ch_en[g]),
            .clr     (ch_clr[g]),
            .load    (wrHit || (IS_ADJ && lvl_load)),
            .modeWe  (wrHit),
            .oneshot (cfg_oneshot),
            .period  (IS_ADJ ? adjEffQ : baseQ[g]),
            .tick    (tick[g]),
            .done    (done[g])
        );
    end

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator with a per-cycle behavioural reference model.
module tb_tick_generator;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 27;
    localparam int LVL_W  = 5;
    localparam int DEFP   = 20;
    localparam int STEP   = 3;
    localparam int MINP   = 4;

    logic              Clk100M = 1'b0;
    logic              resetB  = 1'b1;
    logic [NUM_CH-1:0] ch_en   = '0;
    logic [NUM_CH-1:0] ch_clr  = '0;
    logic              cfg_we  = 1'b0;
    logic [1:0]        cfg_ch  = '0;
    logic [CNT_W-1:0]  cfg_period = '0;
    logic              cfg_oneshot = 1'b0;
    logic              lvl_load = 1'b0;
    logic [LVL_W-1:0]  level    = '0;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] done;
    logic [CNT_W-1:0]  eff_period;

    int tests  = 0;
    int failed = 0;

    tick_generator #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LVL_W(LVL_W), .ADJ_CH(0),
        .LVL_STEP(STEP), .MIN_PERIOD(MINP), .DEFAULT_PERIOD(DEFP)
    ) dut (
        .Clk100M(Clk100M), .resetB(resetB), .ch_en(ch_en), .ch_clr(ch_clr),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
        .cfg_oneshot(cfg_oneshot), .lvl_load(lvl_load), .level(level),
        .tick(tick), .done(done), .eff_period(eff_period)
    );

    always #5 Clk100M = ~Clk100M;

    // Reference model: counts enabled edges since the last restart; a tick is due
    // whenever that count is a multiple of the period (only the first time for one-shot).
    int          runEdges [NUM_CH];
    bit          fired    [NUM_CH];
    int          mBase    [NUM_CH];
    bit          mOneshot [NUM_CH];
    int          mLvl;
    int          mEff;
    logic [2:0]  mTick = '0;
    logic [2:0]  mDone = '0;
    bit          mValid = 0;

    always @(posedge Clk100M) begin
        if (resetB) begin
            for (int i = 0; i < NUM_CH; i++) begin
                runEdges[i] = 0; fired[i] = 0; mBase[i] = DEFP; mOneshot[i] = 0;
            end
            mTick = '0; mDone = '0; mLvl = 0; mEff = DEFP; mValid = 1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                int p;
                bit restart;
                p = (i == 0) ? mEff : mBase[i];
                restart = ch_clr[i] || (cfg_we && int'(cfg_ch) == i) || (i == 0 && lvl_load);
                mTick[i] = 1'b0;
                if (ch_clr[i]) begin
                    fired[i] = 0; mDone[i] = 1'b0;
                end
                if (restart) begin
                    runEdges[i] = 0;
                end else if (ch_en[i] && !fired[i]) begin
                    runEdges[i]++;
                    if (mOneshot[i]) begin
                        if (runEdges[i] == p) begin
                            mTick[i] = 1'b1; fired[i] = 1; mDone[i] = 1'b1;
                        end
                    end else if (runEdges[i] % p == 0) begin
                        mTick[i] = 1'b1;
                    end
                end
            end
            if (cfg_we && int'(cfg_ch) < NUM_CH) begin
                mBase[cfg_ch]    = (cfg_period == 0) ? 1 : int'(cfg_period);
                mOneshot[cfg_ch] = cfg_oneshot;
            end
            if (lvl_load) mLvl = int'(level);
            if (lvl_load || (cfg_we && cfg_ch == 0)) begin
                int d;
                d = mBase[0] - mLvl * STEP;
                mEff = (d < MINP) ? MINP : d;
            end
        end
    end

    always @(negedge Clk100M) begin
        if (mValid) begin
            tests++;
            if (tick !== mTick || done !== mDone || eff_period !== CNT_W'(mEff)) begin
                failed++;
                $display("FAIL model t=%0t tick=%b/%b done=%b/%b eff=%0d/%0d (actual/required)",
                         $time, tick, mTick, done, mDone, eff_period, mEff);
            end
        end
    end

    task automatic cyc();
        @(posedge Clk100M);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic waitTick(input int ch, input string name, input int expN);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick[ch] && n < 60);
        chk(name, n, expN);
    endtask

    task automatic pulseLvl(input int lv);
        lvl_load = 1'b1;
        level    = LVL_W'(lv);
        cyc();
        lvl_load = 1'b0;
    endtask

    task automatic cfgWrite(input int ch, input int p, input bit os);
        cfg_we      = 1'b1;
        cfg_ch      = 2'(ch);
        cfg_period  = CNT_W'(p);
        cfg_oneshot = os;
        cyc();
        cfg_we = 1'b0;
    endtask

    initial begin
        int sum;

        // 1: reset values, then all channels every 20 cycles
        cyc(); cyc();
        chk("rst_eff", int'(eff_period), 20);
        chk("rst_tick", int'(tick), 0);
        chk("rst_done", int'(done), 0);
        resetB = 1'b0;
        ch_en  = '1;
        waitTick(0, "t1_first", 20);
        chk("t1_all", int'(tick), 7);
        waitTick(0, "t1_second", 20);

        // 2: level 2 -> 14
        pulseLvl(2);
        chk("t2_eff", int'(eff_period), 14);
        waitTick(0, "t2_tick", 14);

        // 3: clamp to floor, then level 5 -> 5
        pulseLvl(7);
        chk("t3_eff_clamp", int'(eff_period), 4);
        waitTick(0, "t3_tick_a", 4);
        waitTick(0, "t3_tick_b", 4);
        pulseLvl(5);
        chk("t3_eff5", int'(eff_period), 5);
        waitTick(0, "t3_tick5", 5);

        // 4: one-shot on ch1
        cfgWrite(1, 6, 1'b1);
        waitTick(1, "t4_oneshot", 6);
        chk("t4_done", int'(done[1]), 1);
        sum = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            sum += int'(tick[1]);
        end
        chk("t4_silent", sum, 0);
        ch_clr = 3'b010;
        cyc();
        ch_clr = '0;
        chk("t4_clr_done", int'(done[1]), 0);
        waitTick(1, "t4_rearm", 6);

        // 5: enable gating on ch2
        ch_clr = 3'b100;
        cyc();
        ch_clr = '0;
        sum = 0;
        for (int i = 0; i < 10; i++) begin cyc(); sum += int'(tick[2]); end
        ch_en[2] = 1'b0;
        for (int i = 0; i < 5; i++) begin cyc(); sum += int'(tick[2]); end
        ch_en[2] = 1'b1;
        for (int i = 0; i < 9; i++) begin cyc(); sum += int'(tick[2]); end
        chk("t5_no_early", sum, 0);
        cyc();
        chk("t5_tick20", int'(tick[2]), 1);

        // period 0 written -> period 1
        cfgWrite(2, 0, 1'b0);
        waitTick(2, "pmin_a", 1);
        waitTick(2, "pmin_b", 1);

        // 6: reset mid-count, then collision
        for (int i = 0; i < 7; i++) cyc();
        resetB = 1'b1;
        cyc();
        chk("t6_rst_tick", int'(tick), 0);
        chk("t6_rst_eff", int'(eff_period), 20);
        chk("t6_rst_done", int'(done), 0);
        resetB = 1'b0;
        waitTick(2, "t6_ch2", 20);
        chk("t6_all", int'(tick), 7);
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = CNT_W'(30); cfg_oneshot = 1'b0;
        lvl_load = 1'b1; level = LVL_W'(2);
        cyc();
        cfg_we = 1'b0; lvl_load = 1'b0;
        chk("t6_coll_eff", int'(eff_period), 24);
        waitTick(0, "t6_coll_tick", 24);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
